// File: rtl/tx_uart_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_pkg / tx_uart_if
// Purpose  : UART transmitter. One byte is accepted per valid/ready handshake
//            and serialised as start / data (LSB first) / optional parity /
//            stop bits on tx_out. The bit period, data width, parity and stop
//            bit count are runtime configurable. All framing inputs are
//            captured at accept time, so the frame in flight is immune to
//            later input changes.
// Ports    : clk             system clock
//            reset           asynchronous, active-low reset
//            enable          allows new frames to be accepted
//            samples_per_bit clock cycles per bit (0 behaves as 1)
//            data_width      data bits per frame, clamped to 5..8
//            stop_bits       stop bits per frame (0 -> 1, 3 -> 2)
//            parity          NO_PARITY / EVEN_PARITY / ODD_PARITY
//            data, valid     byte to send and its qualifier
//            ready           block can accept a byte this cycle
//            tx_out          serial line, idles high, driven from a flop
//            done            one-cycle pulse after the last stop bit
//            state_o         FSM state (IDLE=0 START=1 DATA=2 PARITY=3 STOP=4)
// Revision : 1.0 - initial release
// ============================================================================

package uart_pkg;
    typedef enum logic [1:0] {
        NO_PARITY   = 2'd0,
        EVEN_PARITY = 2'd1,
        ODD_PARITY  = 2'd2
    } parity_t;
endpackage

module tx_uart_if
    import uart_pkg::*;
#(
    parameter int SAMPLE_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [SAMPLE_WIDTH-1:0] samples_per_bit,
    input  logic [3:0]              data_width,
    input  logic [1:0]              stop_bits,
    input  parity_t                 parity,
    input  logic [7:0]              data,
    input  logic                    valid,
    output logic                    ready,
    output logic                    tx_out,
    output logic                    done,
    output logic [3:0]              state_o
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_START  = 4'd1,
        S_DATA   = 4'd2,
        S_PARITY = 4'd3,
        S_STOP   = 4'd4
    } state_t;

    localparam logic [SAMPLE_WIDTH-1:0] c_one = {{(SAMPLE_WIDTH-1){1'b0}}, 1'b1};

    state_t                  r_state;
    logic                    r_tx;
    logic                    r_done;
    logic [7:0]              r_shift;      // remaining data bits, bit 0 is on the line
    logic [3:0]              r_width;      // clamped data width
    logic                    r_par_en;
    logic                    r_par_bit;    // parity bit precomputed at accept
    logic                    r_two_stops;
    logic [SAMPLE_WIDTH-1:0] r_last;       // terminal value of the bit counter (N-1)
    logic [SAMPLE_WIDTH-1:0] r_cnt;
    logic [3:0]              r_bit_idx;
    logic                    r_stop_idx;

    logic [3:0]              w_width;
    logic [7:0]              w_mask;
    logic                    w_xor;
    logic                    w_par_bit;
    logic [SAMPLE_WIDTH-1:0] w_last;
    logic                    w_bit_end;

    // Framing values derived from the live inputs; only sampled at accept.
    assign w_width   = (data_width < 4'd5) ? 4'd5 :
                       (data_width > 4'd8) ? 4'd8 : data_width;
    assign w_mask    = 8'hFF >> (4'd8 - w_width);
    assign w_xor     = ^(data & w_mask);
    assign w_par_bit = (parity == ODD_PARITY) ? ~w_xor : w_xor;
    assign w_last    = (samples_per_bit == '0) ? '0 : (samples_per_bit - c_one);
    assign w_bit_end = (r_cnt == r_last);

    // Gated by the reset pin so nothing is offered while reset is held and
    // ready follows enable immediately on release.
    assign ready   = reset && (r_state == S_IDLE) && enable;
    assign tx_out  = r_tx;
    assign done    = r_done;
    assign state_o = r_state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_tx        <= 1'b1;
            r_done      <= 1'b0;
            r_shift     <= 8'd0;
            r_width     <= 4'd0;
            r_par_en    <= 1'b0;
            r_par_bit   <= 1'b0;
            r_two_stops <= 1'b0;
            r_last      <= '0;
            r_cnt       <= '0;
            r_bit_idx   <= 4'd0;
            r_stop_idx  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_tx  <= 1'b1;
                    r_cnt <= '0;
                    if (valid && ready) begin
                        r_shift     <= data;
                        r_width     <= w_width;
                        r_par_en    <= (parity != NO_PARITY);
                        r_par_bit   <= w_par_bit;
                        r_two_stops <= stop_bits[1];
                        r_last      <= w_last;
                        r_tx        <= 1'b0;
                        r_state     <= S_START;
                    end
                end

                S_START: begin
                    if (w_bit_end) begin
                        r_cnt     <= '0;
                        r_bit_idx <= 4'd0;
                        r_tx      <= r_shift[0];
                        r_state   <= S_DATA;
                    end else begin
                        r_cnt <= r_cnt + c_one;
                    end
                end

                S_DATA: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        if (r_bit_idx == (r_width - 4'd1)) begin
                            if (r_par_en) begin
                                r_tx    <= r_par_bit;
                                r_state <= S_PARITY;
                            end else begin
                                r_tx       <= 1'b1;
                                r_stop_idx <= 1'b0;
                                r_state    <= S_STOP;
                            end
                        end else begin
                            r_bit_idx <= r_bit_idx + 4'd1;
                            r_shift   <= r_shift >> 1;
                            r_tx      <= r_shift[1];
                        end
                    end else begin
                        r_cnt <= r_cnt + c_one;
                    end
                end

                S_PARITY: begin
                    if (w_bit_end) begin
                        r_cnt      <= '0;
                        r_tx       <= 1'b1;
                        r_stop_idx <= 1'b0;
                        r_state    <= S_STOP;
                    end else begin
                        r_cnt <= r_cnt + c_one;
                    end
                end

                S_STOP: begin
                    r_tx <= 1'b1;
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        if (r_stop_idx == r_two_stops) begin
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_stop_idx <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_one;
                    end
                end

                default: begin
                    r_tx    <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_tx_uart_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_tx_uart_if
// Purpose  : Self-checking bench for tx_uart_if. Stimulus pushes the expected
//            frame description into a queue at each accept; an independent
//            monitor watches the line, pops the description when a start bit
//            appears and compares every bit period, the state code, ready,
//            done and the frame length.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tx_uart_if;
    import uart_pkg::*;

    localparam int SW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          enable = 1'b0;
    logic [SW-1:0] samples_per_bit = '0;
    logic [3:0]    data_width = 4'd8;
    logic [1:0]    stop_bits = 2'd1;
    parity_t       parity = NO_PARITY;
    logic [7:0]    data = 8'd0;
    logic          valid = 1'b0;
    logic          ready;
    logic          tx_out;
    logic          done;
    logic [3:0]    state_o;

    tx_uart_if #(.SAMPLE_WIDTH(SW)) dut (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
        .samples_per_bit (samples_per_bit),
        .data_width      (data_width),
        .stop_bits       (stop_bits),
        .parity          (parity),
        .data            (data),
        .valid           (valid),
        .ready           (ready),
        .tx_out          (tx_out),
        .done            (done),
        .state_o         (state_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] d;
        int n;          // clocks per bit
        int w;          // data bits
        int p;          // 1 when a parity bit is sent
        int pol;        // 1 for odd parity
        int s;          // stop bits
        int start_cyc;  // cycle in which the start bit must first appear
    } frame_t;

    frame_t exp_q[$];
    int     starts[$];
    int     n_tests = 0;
    int     n_fail  = 0;
    bit     in_frame = 1'b0;

    task automatic check(string name, int act, int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    function automatic frame_t model(logic [7:0] d, int spb_v, int dw, int sb, int par);
        frame_t f;
        f.d   = d;
        f.n   = (spb_v == 0) ? 1 : spb_v;
        f.w   = (dw < 5) ? 5 : ((dw > 8) ? 8 : dw);
        f.s   = (sb >= 2) ? 2 : 1;
        f.p   = (par != 0) ? 1 : 0;
        f.pol = (par == 2) ? 1 : 0;
        f.start_cyc = 0;
        return f;
    endfunction

    // Line level and state code of bit position b within the frame.
    function automatic bit exp_bit(frame_t f, int b, output int code);
        int ones;
        if (b == 0) begin
            code = 1;
            return 1'b0;
        end else if (b <= f.w) begin
            code = 2;
            return f.d[b-1];
        end else if (f.p == 1 && b == f.w + 1) begin
            code = 3;
            ones = 0;
            for (int i = 0; i < f.w; i++) ones += int'(f.d[i]);
            return ((ones % 2) ^ f.pol) != 0;
        end else begin
            code = 4;
            return 1'b1;
        end
    endfunction

    // ---------------- monitor ----------------
    initial begin : monitor
        int fidx = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                in_frame = 1'b0;
            end else if (tx_out == 1'b0) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_start: start bit at cycle %0d, no frame expected", cyc);
                    while (tx_out == 1'b0 && reset) @(negedge clk);
                end else begin
                    frame_t f;
                    int     len;
                    bit     abort;
                    f = exp_q.pop_front();
                    in_frame = 1'b1;
                    starts.push_back(cyc);
                    check($sformatf("f%0d_start_latency", fidx), cyc, f.start_cyc);
                    len   = 1 + f.w + f.p + f.s;
                    abort = 1'b0;
                    for (int b = 0; b < len && !abort; b++) begin
                        int code, req, act, smp;
                        bit eb;
                        eb  = exp_bit(f, b, code);
                        req = int'({2'b00, eb, code[3:0]});
                        act = req;
                        for (int k = 0; k < f.n; k++) begin
                            if (!(b == 0 && k == 0)) @(negedge clk);
                            if (!reset) begin
                                abort = 1'b1;
                                break;
                            end
                            smp = int'({done, ready, tx_out, state_o});
                            if (smp != req && act == req) act = smp;
                        end
                        if (!abort)
                            check($sformatf("f%0d_bit%0d_{done,ready,tx,state}", fidx, b), act, req);
                    end
                    if (!abort) begin
                        @(negedge clk);
                        check($sformatf("f%0d_done", fidx), int'(done), 1);
                        check($sformatf("f%0d_end_state", fidx), int'(state_o), 0);
                        check($sformatf("f%0d_frame_len", fidx), cyc - f.start_cyc, f.n * len);
                    end
                    fidx++;
                    in_frame = 1'b0;
                end
            end else if (done) begin
                check("spurious_done", int'(done), 0);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(logic [7:0] d, int spb_v, int dw, int sb, int par, bit hold);
        frame_t f;
        bit     accepted = 1'b0;
        data            = d;
        samples_per_bit = spb_v;
        data_width      = dw[3:0];
        stop_bits       = sb[1:0];
        parity          = parity_t'(par[1:0]);
        valid           = 1'b1;
        for (int t = 0; t < 10000; t++) begin
            if (ready) begin
                f = model(d, spb_v, dw, sb, par);
                f.start_cyc = cyc + 1;
                exp_q.push_back(f);
                accepted = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!accepted) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: data 0x%0h never accepted", d);
        end
        @(negedge clk);
        if (!hold) valid = 1'b0;
        // Scramble the inputs to show the frame in flight was latched.
        data            = 8'($urandom);
        data_width      = 4'($urandom);
        stop_bits       = 2'($urandom);
        parity          = parity_t'(2'($urandom_range(0, 2)));
        samples_per_bit = $urandom_range(0, 7);
    endtask

    task automatic wait_idle();
        for (int t = 0; t < 20000; t++) begin
            if (exp_q.size() == 0 && !in_frame) break;
            @(negedge clk);
        end
        check("drain", exp_q.size() + int'(in_frame), 0);
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int cnt;
        int nstarts;
        enable = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_tx", int'(tx_out), 1);
        check("rst_ready", int'(ready), 0);
        check("rst_done", int'(done), 0);
        check("rst_state", int'(state_o), 0);
        reset = 1'b1;
        #1;
        check("post_rst_ready", int'(ready), 1);
        @(negedge clk);

        // 8N1, N=434
        send(8'h55, 434, 8, 1, 0, 1'b0);
        wait_idle();
        // 7E2, N=4
        send(8'h83, 4, 7, 2, 1, 1'b0);
        wait_idle();
        // 8O1, N=1
        send(8'hFF, 1, 8, 1, 2, 1'b0);
        wait_idle();
        // back-to-back with valid held
        send(8'hA5, 8, 8, 1, 0, 1'b1);
        send(8'h3C, 8, 8, 1, 0, 1'b0);
        wait_idle();
        check("b2b_gap", starts[starts.size()-1] - starts[starts.size()-2], 81);
        // clamping: 5 data bits, 1 stop, 1 clk/bit
        send(8'h1B, 0, 3, 0, 0, 1'b0);
        wait_idle();

        // enable dropped mid-frame
        send(8'h5A, 4, 8, 1, 0, 1'b0);
        repeat (19) @(negedge clk);
        enable = 1'b0;
        data   = 8'hC3;
        valid  = 1'b1;
        wait_idle();
        nstarts = starts.size();
        cnt = 0;
        repeat (60) begin
            @(negedge clk);
            if (ready) cnt++;
        end
        check("ready_while_disabled", cnt, 0);
        check("no_accept_while_disabled", starts.size(), nstarts);
        valid  = 1'b0;
        enable = 1'b1;
        @(negedge clk);

        // reset asserted mid-frame
        send(8'h96, 4, 8, 1, 1, 1'b0);
        repeat (28) @(negedge clk);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("midrst_tx", int'(tx_out), 1);
        check("midrst_state", int'(state_o), 0);
        check("midrst_done", int'(done), 0);
        check("midrst_ready", int'(ready), 0);
        cnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) cnt++;
        end
        check("midrst_no_done", cnt, 0);
        reset = 1'b1;
        @(negedge clk);
        check("rerst_state", int'(state_o), 0);
        check("rerst_tx", int'(tx_out), 1);
        check("rerst_ready", int'(ready), 1);
        check("rerst_queue", exp_q.size(), 0);

        // randomized frames
        for (int i = 0; i < 40; i++) begin
            bit hold;
            hold = (i < 39) && ($urandom_range(0, 3) == 0);
            send(8'($urandom), $urandom_range(0, 5), $urandom_range(0, 15),
                 $urandom_range(0, 3), $urandom_range(0, 2), hold);
        end
        wait_idle();
        repeat (5) @(negedge clk);
        check("final_queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/tx_uart_if.md
Name: tx_uart_if

Overview:
UART transmitter, the transmit-side counterpart of rx_uart_if on the de0nano template. It serialises one parallel byte per valid/ready handshake into a start/data/parity/stop frame on a single TX pin (a JP1 GPIO). Framing is runtime-configurable: bit period, data width, parity and stop bits. It uses the parity_t type from uart_pkg, so its configuration matches the receiver's.

Parameters:
SAMPLE_WIDTH, 32, width of samples_per_bit and of the internal bit-period counter.

Ports:
clk  input  1  system clock (CLK50MHZ).
reset  input  1  asynchronous, active-low reset.
enable  input  1  permits acceptance of new frames; does not abort a frame in flight.
samples_per_bit  input  SAMPLE_WIDTH  clock cycles per bit (434 = 115200 baud at 50 MHz).
data_width  input  4  data bits per frame; legal range 5..8.
stop_bits  input  2  stop bits per frame; legal values 1 or 2.
parity  input  parity_t  NO_PARITY, EVEN_PARITY or ODD_PARITY.
data  input  8  byte to send, LSB first.
valid  input  1  data is presented.
ready  output  1  block can accept a byte.
tx_out  output  1  serial line; idles high.
done  output  1  one-cycle pulse when the last stop bit completes.
state_o  output  4  current FSM state.

Behaviour:
- Reset (reset=0, asynchronous) forces: tx_out=1, ready=0, done=0, state_o=IDLE (0), all counters 0. The first cycle after release: ready=enable.
- State encoding on state_o: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4. No other codes occur.
- ready = (state==IDLE) && enable. This is combinational from the registered state.
- Accept occurs on the clk edge where valid && ready. At that edge the block latches data, data_width, stop_bits, parity and samples_per_bit. Later input changes do not affect the frame in flight.
- Latency: tx_out drives 0 (start bit) starting the cycle after the accept edge.
- Bit timing: each bit holds for exactly N clocks, where N = latched samples_per_bit. N=0 is treated as 1.
- START: one bit period at 0, then go to DATA.
- DATA: bits data[0]..data[W-1], LSB first, one bit period each.
  - W = latched data_width, clamped: values below 5 use 5, values above 8 use 8.
  - After the last data bit: go to PARITY if parity != NO_PARITY, otherwise go to STOP.
- PARITY: one bit period.
  - EVEN_PARITY sends the XOR of the W transmitted bits.
  - ODD_PARITY sends the inverse of that XOR.
  - Bits above W never contribute.
- STOP: tx_out=1 for S bit periods. S = latched stop_bits, with 0 treated as 1 and 3 treated as 2.
  - On the final clock of the last stop bit, done pulses high for 1 cycle and state returns to IDLE.
- Total frame length = N*(1+W+P+S) clocks, where P=1 if parity is enabled, else 0.
- Back-to-back: if valid is held and enable=1, the next accept occurs on the first IDLE cycle. The next start bit therefore follows the last stop bit with exactly 1 idle-high cycle.
- enable dropped mid-frame: the current frame completes normally, then the block stays IDLE with ready=0.
- valid asserted while ready=0: ignored, not queued. The sender must hold valid.
- Reset asserted mid-frame: the line returns high immediately and no done is generated. The partial frame is abandoned.
- Counter arithmetic is unsigned SAMPLE_WIDTH. The bit-period counter counts 0..N-1 and wraps at N-1 with a bit advance. No overflow is possible for N ≤ 2^SAMPLE_WIDTH-1.
- tx_out is driven directly from a flop, so it is glitch-free.

Test Plan:
- 8N1, N=434, data=0x55, valid pulse in IDLE -> start low 434 clks, then bits 1,0,1,0,1,0,1,0, then 434 clks high. done pulses at clk 4340 after accept. ready=0 throughout the frame.
- 7E2, N=4, data=0x83 (W=7 sends 0000011 LSB-first as 1,1,0,0,0,0,0) -> parity bit 0, two stop bits. Frame = 44 clks. Bit 7 of data is never sent.
- 8O1, N=1, data=0xFF -> parity bit 1, frame = 11 clks. state_o sequence is 1,2×8,3,4,0.
- Back-to-back: valid held with 0xA5 then 0x3C, 8N1, N=8 -> two frames of 80 clks each, separated by exactly 1 idle cycle. Decode via an rx_uart_if loopback returns 0xA5, 0x3C.
- Mid-frame disruption: enable=0 at clk 20 of a frame -> frame finishes and no new accept while valid=1. Separately, reset=0 at clk 30 -> tx_out=1 and state_o=0 within the same cycle (asynchronous), with no done pulse.
- Clamping: data_width=3, stop_bits=0, samples_per_bit=0 -> 5 data bits, 1 stop bit, 1 clk/bit. Frame = 7 clks.
